// File: rtl/lut_prog.sv
// lut_prog: programmable 2^WIDTH x 1-bit pattern lookup table.
// The table is written through a config port and read through a
// registered, fully pipelined lookup port. cfg_clr starts a sequenced
// clear that walks every entry once, one entry per cycle.
// Optional feature macro: LUT_HIT_CNT_EN (saturating count of y=1 results).
//
// Handshake: a lookup is accepted in any cycle where x_valid=1, the block
// is idle and no clear is being started; its result appears one cycle
// later with y_valid=1. There is no backpressure. Requests that are not
// accepted are dropped, and y is forced to 0 whenever y_valid=0.
module lut_prog #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_addr,
  input  logic             cfg_data,
  input  logic             cfg_clr,
  input  logic             x_valid,
  input  logic [WIDTH-1:0] x,
  output logic             y_valid,
  output logic             y,
  output logic             busy,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam int DEPTH = 1 << WIDTH;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] idx_q, idx_d;
  logic [DEPTH-1:0] tbl_q;
  logic             accept;
  logic             wr_en;

  // A lookup or write only lands while idle and when no clear starts now.
  assign accept = x_valid & (state_q == IDLE) & ~cfg_clr;
  assign wr_en  = cfg_we  & (state_q == IDLE) & ~cfg_clr;
  assign busy   = (state_q == CLEAR);

  // State and clear-index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: a clear request (re)starts the walk at entry 0.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (cfg_clr) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        if (cfg_clr) begin
          idx_d = '0;
        end else if (idx_q == WIDTH'(DEPTH - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Truth table storage: cleared entry-by-entry in CLEAR, written in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_q <= '0;
    end else if (state_q == CLEAR) begin
      tbl_q[idx_q] <= 1'b0;
    end else if (wr_en) begin
      tbl_q[cfg_addr] <= cfg_data;
    end
  end

  // Registered lookup; reads the pre-write table so same-cycle writes are not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_valid <= 1'b0;
      y       <= 1'b0;
    end else begin
      y_valid <= accept;
      y       <= accept & tbl_q[x];
    end
  end

`ifdef LUT_HIT_CNT_EN
  logic [CNT_W-1:0] hit_q;

  // Saturating hit counter; a clear request zeroes it at the edge CLEAR begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q <= '0;
    end else if (cfg_clr) begin
      hit_q <= '0;
    end else if (y_valid && y && (hit_q != {CNT_W{1'b1}})) begin
      hit_q <= hit_q + 1'b1;
    end
  end

  assign hit_cnt = hit_q;
`else
  assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_lut_prog.sv
// tb_lut_prog: directed and random stimulus against a table-level model.
module tb_lut_prog;

  localparam int WIDTH = 4;
  localparam int CNT_W = 4;
  localparam int DEPTH = 16;
  localparam int HIT_MAX = 15;

  logic             clk;
  logic             rst_n;
  logic             cfg_we;
  logic [WIDTH-1:0] cfg_addr;
  logic             cfg_data;
  logic             cfg_clr;
  logic             x_valid;
  logic [WIDTH-1:0] x;
  logic             y_valid;
  logic             y;
  logic             busy;
  logic [CNT_W-1:0] hit_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: table contents, remaining busy cycles, hit count,
  // and the outputs the DUT should currently present.
  bit m_tbl[DEPTH];
  int m_busy_left;
  int m_hits;
  bit m_yv;
  bit m_y;

  lut_prog #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cfg_clr  (cfg_clr),
    .x_valid  (x_valid),
    .x        (x),
    .y_valid  (y_valid),
    .y        (y),
    .busy     (busy),
    .hit_cnt  (hit_cnt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_hit();
`ifdef LUT_HIT_CNT_EN
    return m_hits;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_tbl[i] = 1'b0;
    m_busy_left = 0;
    m_hits      = 0;
    m_yv        = 1'b0;
    m_y         = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".y_valid"}, 8'(y_valid), 8'(m_yv));
    chk({tag, ".y"},       8'(y),       8'(m_y));
    chk({tag, ".busy"},    8'(busy),    8'(m_busy_left > 0));
    chk({tag, ".hit_cnt"}, 8'(hit_cnt), 8'(exp_hit()));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, compare.
  task automatic step(input bit we, input int addr, input bit data,
                      input bit clr, input bit xv, input int xa, input string tag);
    bit idle;
    bit n_yv;
    bit n_y;
    cfg_we   = we;
    cfg_addr = WIDTH'(addr);
    cfg_data = data;
    cfg_clr  = clr;
    x_valid  = xv;
    x        = WIDTH'(xa);
    @(posedge clk);
    #1;
    idle = (m_busy_left == 0);
    n_yv = xv && idle && !clr;
    n_y  = n_yv && m_tbl[xa];
    if (clr) m_hits = 0;
    else if (m_yv && m_y && m_hits < HIT_MAX) m_hits++;
    if (clr) begin
      m_busy_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) m_tbl[i] = 1'b0;
    end else begin
      if (m_busy_left > 0) m_busy_left--;
      if (idle && we) m_tbl[addr] = data;
    end
    m_yv = n_yv;
    m_y  = n_y;
    check_outputs(tag);
  endtask

  task automatic idle_step(input string tag);
    step(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, tag);
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 0, 1'b0, 1'b0, 1'b1, i, tag);
    idle_step(tag);
    idle_step(tag);
  endtask

  task automatic write(input int addr, input bit data);
    step(1'b1, addr, data, 1'b0, 1'b0, 0, "write");
  endtask

  initial begin
    int busy_cycles;
    rst_n    = 1'b0;
    cfg_we   = 1'b0;
    cfg_addr = '0;
    cfg_data = 1'b0;
    cfg_clr  = 1'b0;
    x_valid  = 1'b0;
    x        = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Program 0x3, 0x7, 0xB and sweep all patterns.
    write(3, 1'b1);
    write(7, 1'b1);
    write(11, 1'b1);
    sweep("sweep1");
`ifdef LUT_HIT_CNT_EN
    chk("sweep1.hits3", 8'(hit_cnt), 8'd3);
`else
    chk("sweep1.hits0", 8'(hit_cnt), 8'd0);
`endif

    // Read-before-write on address 0x5.
    step(1'b1, 5, 1'b1, 1'b0, 1'b1, 5, "rbw.old");
    chk("rbw.old_y", 8'(y), 8'd0);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1, 5, "rbw.new");
    chk("rbw.new_y", 8'(y), 8'd1);

    // Clear with lookups and writes hammered in while busy.
    step(1'b1, 2, 1'b1, 1'b1, 1'b1, 3, "clr.start");
    busy_cycles = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      busy_cycles++;
      step(1'b1, $urandom_range(0, DEPTH - 1), 1'b1, 1'b0, 1'b1,
           $urandom_range(0, DEPTH - 1), "clr.busy");
    end
    chk("clr.busy_len", 8'(busy_cycles), 8'd16);
    sweep("clr.sweep");

    // Clear restart: second pulse five cycles after the first.
    write(9, 1'b1);
    write(0, 1'b1);
    write(15, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0, 0, "rst.c1");
    busy_cycles = 1;
    for (int i = 0; i < 4; i++) begin
      idle_step("rst.wait");
      busy_cycles++;
    end
    step(1'b0, 0, 1'b0, 1'b1, 1'b0, 0, "rst.c2");
    for (int i = 0; i < 40 && busy; i++) begin
      busy_cycles++;
      idle_step("rst.busy");
    end
    chk("restart.busy_len", 8'(busy_cycles), 8'd21);
    sweep("restart.sweep");

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, DEPTH - 1), $urandom_range(0, 1) == 1,
           $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, DEPTH - 1), "rand");
    end
    for (int i = 0; i < 20; i++) idle_step("drain");

    // Saturation: many hits on one programmed entry.
    write(1, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0, 0, "sat.clr");
    for (int i = 0; i < 20 && busy; i++) idle_step("sat.busy");
    write(1, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 0, 1'b0, 1'b0, 1'b1, 1, "sat.look");
    idle_step("sat.tail");
    idle_step("sat.tail");
`ifdef LUT_HIT_CNT_EN
    chk("sat.hold15", 8'(hit_cnt), 8'd15);
`endif

    // Async reset off-edge while clearing.
    step(1'b0, 0, 1'b0, 1'b1, 1'b0, 0, "ar.clr");
    idle_step("ar.busy");
    idle_step("ar.busy");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    sweep("ar.sweep");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
